// File: rtl/operand_loader_pkg.sv
// Shared definitions for the ALU operand front end.
// Opcode encodings, default widths and load-flag bit positions.
package operand_loader_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OP_WIDTH   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // Bit positions inside o_loaded = {op, b, a}
  localparam int LD_A  = 0;
  localparam int LD_B  = 1;
  localparam int LD_OP = 2;

  typedef struct packed {
    logic op;
    logic b;
    logic a;
  } press_t;

  // Counter width that can hold 0 .. n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_loader_btn_debouncer.sv
// One button conditioner: 2-flop sync, counter debouncer, rise detect.
// Ports: i_clock, i_reset, i_btn (raw) -> o_press (1-cycle pulse).
module btn_debouncer
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic          deb_dly_q, deb_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d   = i_btn;
    sync2_d   = sync1_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    if (sync2_q == deb_q) begin
      // any disagreement shorter than the window is forgotten
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_press = deb_q & ~deb_dly_q;

endmodule

// File: rtl/operand_loader.sv
// Latches the switch bank into operand A/B and opcode on button presses.
// Ports: i_clock, i_reset, i_sw, i_btn_{a,b,op} -> o_data_a/b, o_op,
// o_loaded {op,b,a}, o_valid (all loaded), o_update (fresh-inputs pulse).
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int OP_WIDTH        = DEF_OP_WIDTH,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_sw,
  input  logic                  i_btn_a,
  input  logic                  i_btn_b,
  input  logic                  i_btn_op,
  output logic [DATA_WIDTH-1:0] o_data_a,
  output logic [DATA_WIDTH-1:0] o_data_b,
  output logic [OP_WIDTH-1:0]   o_op,
  output logic [2:0]            o_loaded,
  output logic                  o_valid,
  output logic                  o_update
);

  press_t press;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_btn   (i_btn_a),
    .o_press (press.a)
  );

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_btn   (i_btn_b),
    .o_press (press.b)
  );

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_btn   (i_btn_op),
    .o_press (press.op)
  );

  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [2:0]            loaded_q, loaded_d;
  logic                  wr_q, wr_d;
  logic                  upd_q, upd_d;

  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    op_d     = op_q;
    loaded_d = loaded_q;
    wr_d     = press.a | press.b | press.op;
    // wr_q marks the edge a register was written; loaded_q then
    // already holds the post-write flags.
    upd_d    = wr_q & (&loaded_q);
    if (press.a) begin
      data_a_d       = i_sw;
      loaded_d[LD_A] = 1'b1;
    end
    if (press.b) begin
      data_b_d       = i_sw;
      loaded_d[LD_B] = 1'b1;
    end
    if (press.op) begin
      op_d            = i_sw[OP_WIDTH-1:0];
      loaded_d[LD_OP] = 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      data_a_q <= '0;
      data_b_q <= '0;
      op_q     <= '0;
      loaded_q <= '0;
      wr_q     <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      op_q     <= op_d;
      loaded_q <= loaded_d;
      wr_q     <= wr_d;
      upd_q    <= upd_d;
    end
  end

  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;
  assign o_op     = op_q;
  assign o_loaded = loaded_q;
  assign o_valid  = &loaded_q;
  assign o_update = upd_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled 1 time unit after rising edges.
module tb_operand_loader;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic       btn_a, btn_b, btn_op;
  logic [7:0] data_a, data_b;
  logic [5:0] op;
  logic [2:0] loaded;
  logic       valid, update;

  int errs;
  int checks;
  int upd_cnt;
  int base;

  operand_loader #(
    .DATA_WIDTH(8),
    .OP_WIDTH(6),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_sw     (sw),
    .i_btn_a  (btn_a),
    .i_btn_b  (btn_b),
    .i_btn_op (btn_op),
    .o_data_a (data_a),
    .o_data_b (data_b),
    .o_op     (op),
    .o_loaded (loaded),
    .o_valid  (valid),
    .o_update (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One count per cycle that o_update is high
  always @(negedge clk) if (update === 1'b1) upd_cnt++;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errs = 0; checks = 0; upd_cnt = 0;
    rst = 1'b1; sw = 8'h00;
    btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
    tick(3);
    chk("rst_data_a", 32'(data_a), 32'h0);
    chk("rst_data_b", 32'(data_b), 32'h0);
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_loaded", 32'(loaded), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_update", 32'(update), 32'h0);
    rst = 1'b0;
    tick(2);

    // glitch of 3 samples: rejected
    sw = 8'h55; btn_a = 1'b1;
    tick(3);
    btn_a = 1'b0;
    tick(12);
    chk("glitch_data_a", 32'(data_a), 32'h0);
    chk("glitch_loaded", 32'(loaded), 32'h0);

    // load A: k is the first edge after btn rises; load at k+6
    sw = 8'hFF; btn_a = 1'b1;
    tick(6);
    chk("a_before", 32'(data_a), 32'h0);
    tick(1);
    chk("a_load", 32'(data_a), 32'hFF);
    chk("a_loaded", 32'(loaded), 32'h1);
    chk("a_valid", 32'(valid), 32'h0);
    tick(3);
    btn_a = 1'b0;
    tick(12);
    chk("a_no_update", 32'(upd_cnt), 32'h0);

    // load B
    sw = 8'h01; btn_b = 1'b1;
    tick(7);
    chk("b_load", 32'(data_b), 32'h01);
    chk("b_loaded", 32'(loaded), 32'h3);
    tick(3);
    btn_b = 1'b0;
    tick(12);

    // load OP -> valid, single o_update one edge after the load
    sw = {2'b00, 6'b100000}; btn_op = 1'b1;
    tick(7);
    chk("op_load", 32'(op), 32'h20);
    chk("op_valid", 32'(valid), 32'h1);
    chk("op_upd_lat", 32'(update), 32'h0);
    tick(1);
    chk("op_upd_hi", 32'(update), 32'h1);
    tick(1);
    chk("op_upd_lo", 32'(update), 32'h0);
    tick(1);
    btn_op = 1'b0;
    tick(12);
    chk("op_upd_cnt", 32'(upd_cnt), 32'h1);

    // hold B for 50+ cycles while switches move after the load
    base = upd_cnt;
    sw = 8'h77; btn_b = 1'b1;
    tick(7);
    chk("hold_load", 32'(data_b), 32'h77);
    sw = 8'h12;
    tick(25);
    sw = 8'hC3;
    tick(25);
    chk("hold_keep", 32'(data_b), 32'h77);
    chk("hold_valid", 32'(valid), 32'h1);
    chk("hold_upd", 32'(upd_cnt - base), 32'h1);
    btn_b = 1'b0;
    tick(12);

    // asynchronous reset mid-cycle with a press in progress
    sw = 8'h99; btn_a = 1'b1;
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("arst_data_a", 32'(data_a), 32'h0);
    chk("arst_data_b", 32'(data_b), 32'h0);
    chk("arst_op", 32'(op), 32'h0);
    chk("arst_loaded", 32'(loaded), 32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    btn_a = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(12);
    chk("arst_noload", 32'(data_a), 32'h0);
    chk("arst_noflag", 32'(loaded), 32'h0);

    // simultaneous A and B
    base = upd_cnt;
    sw = 8'h2A; btn_a = 1'b1; btn_b = 1'b1;
    tick(6);
    chk("sim_before", 32'(loaded), 32'h0);
    tick(1);
    chk("sim_a", 32'(data_a), 32'h2A);
    chk("sim_b", 32'(data_b), 32'h2A);
    chk("sim_loaded", 32'(loaded), 32'h3);
    tick(3);
    btn_a = 1'b0; btn_b = 1'b0;
    tick(12);
    chk("sim_no_upd", 32'(upd_cnt - base), 32'h0);

    // bouncing OP button, then settle high
    base = upd_cnt;
    sw = 8'h26;
    for (int i = 0; i < 10; i++) begin
      btn_op = ((i / 2) % 2) == 1;
      tick(1);
    end
    chk("bnc_none", 32'(loaded), 32'h3);
    btn_op = 1'b1;
    tick(6);
    chk("bnc_before", 32'(loaded), 32'h3);
    tick(1);
    chk("bnc_op", 32'(op), 32'h26);
    chk("bnc_valid", 32'(valid), 32'h1);
    tick(1);
    chk("bnc_upd", 32'(update), 32'h1);
    tick(10);
    btn_op = 1'b0;
    tick(12);
    chk("bnc_upd_cnt", 32'(upd_cnt - base), 32'h1);

    // button held across reset release loads once after normal latency
    btn_a = 1'b1; sw = 8'hB4;
    #2 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("held_before", 32'(data_a), 32'h0);
    tick(1);
    chk("held_load", 32'(data_a), 32'hB4);
    chk("held_loaded", 32'(loaded), 32'h1);
    btn_a = 1'b0;
    tick(12);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
